// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU-side types: the RAM word, the RAM handshake state and the
//   memory arbiter's grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM model handshake; only ACCESS completes a transfer.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Which cache currently owns the RAM port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-ported RAM between the icache and the dcache.
//   The dcache has priority; a starvation counter forces an icache grant
//   after STARVE_LIMIT consecutive dcache completions while iREN is pending.
//   Grants are registered and held for the whole RAM access; on a completing
//   cycle the next owner is chosen immediately so word streams chain with no
//   idle bubble.
//
// Ports
//   CLK, nRST                      clock, async active-low reset
//   iREN, iaddr                    icache read request / word address
//   iwait, iload                   icache stall (low on completion) / data
//   dREN, dWEN, daddr, dstore      dcache read/write request, address, data
//   dwait, dload                   dcache stall (low on completion) / data
//   ramREN, ramWEN, ramaddr,
//   ramstore                       RAM request side
//   ramload, ramstate              RAM read data / handshake state
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arbstate_t        r_state;
  arbstate_t        w_state_nxt;
  arbstate_t        w_arb;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dreq;
  logic             w_access;
  logic             w_dcomp;
  logic             w_icomp;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == 2'(ACCESS));
  assign w_dcomp  = (r_state == DGNT) & w_dreq & w_access;
  assign w_icomp  = (r_state == IGNT) & iREN & w_access;

  // Starvation counter next value. Arbitration looks at this updated value
  // so the icache is granted right after the STARVE_LIMIT-th dcache word.
  always_comb begin
    w_cnt_nxt = r_starve_cnt;
    if (!iREN || w_icomp)
      w_cnt_nxt = '0;
    else if (w_dcomp && (r_starve_cnt != LIMIT))
      w_cnt_nxt = r_starve_cnt + 1'b1;
  end

  // Arbitration: starving icache first, then dcache, then icache.
  always_comb begin
    w_arb = IDLE;
    if (iREN && (w_cnt_nxt == LIMIT))
      w_arb = IGNT;
    else if (w_dreq)
      w_arb = DGNT;
    else if (iREN)
      w_arb = IGNT;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: w_state_nxt = w_arb;
      DGNT: begin
        if (w_dcomp)
          w_state_nxt = w_arb;
        else if (!w_dreq)
          w_state_nxt = IDLE;
      end
      IGNT: begin
        if (w_icomp)
          w_state_nxt = w_arb;
        else if (!iREN)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
    end
  end

  // RAM side follows the registered grant but takes the enables straight
  // from the request lines, so a dropped request stops the RAM at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (r_state)
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: ;
    endcase
  end

  assign iwait = ~w_icomp;
  assign dwait = ~w_dcomp;
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed-vector bench for mem_arbiter (STARVE_LIMIT=4). Inputs for a
//   cycle are applied 1 time unit after its rising edge, outputs are sampled
//   1 unit later.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Move to the start of the next cycle (just after the rising edge).
  task automatic edge1;
    @(posedge CLK);
    #1;
  endtask

  // Sample n cycles and compare who completed in each against exp:
  // 'D' = dcache, 'I' = icache, '-' = none.
  task automatic run_seq(input string tag, input string exp, input int n);
    byte c;
    for (int i = 0; i < n; i++) begin
      edge1;
      #1;
      c = "-";
      if (!dwait) c = "D";
      else if (!iwait) c = "I";
      chk($sformatf("%s[%0d]", tag, i), 32'(c), 32'(exp[i]));
    end
  endtask

  task automatic quiesce;
    edge1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
    repeat (3) edge1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = 32'hA5A5_0001; ramstate = RS_FREE;

    // Reset, then idle.
    #3;
    chk("rst_ramREN",  32'(ramREN), 32'd0);
    chk("rst_ramWEN",  32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore",ramstore, 32'd0);
    chk("rst_iwait",   32'(iwait), 32'd1);
    chk("rst_dwait",   32'(dwait), 32'd1);
    chk("rst_iload",   iload, 32'hA5A5_0001);
    chk("rst_dload",   dload, 32'hA5A5_0001);
    edge1; edge1;
    nRST = 1'b1;
    edge1; edge1;
    #1;
    chk("idle_ramREN", 32'(ramREN), 32'd0);
    chk("idle_ramWEN", 32'(ramWEN), 32'd0);
    chk("idle_waits",  32'({iwait, dwait}), 32'd3);
    chk("idle_ramaddr",ramaddr, 32'd0);

    // Single icache read, ACCESS on the first driven cycle.
    edge1;
    iREN = 1'b1; iaddr = 32'h40; ramstate = RS_ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    chk("i1_t_ramREN", 32'(ramREN), 32'd0);
    chk("i1_t_iwait",  32'(iwait), 32'd1);
    edge1; #1;
    chk("i1_ramREN",  32'(ramREN), 32'd1);
    chk("i1_ramWEN",  32'(ramWEN), 32'd0);
    chk("i1_ramaddr", ramaddr, 32'h40);
    chk("i1_ramstore",ramstore, 32'd0);
    chk("i1_iwait",   32'(iwait), 32'd0);
    chk("i1_dwait",   32'(dwait), 32'd1);
    chk("i1_iload",   iload, 32'hDEAD_BEEF);
    edge1;
    iREN = 1'b0;
    #1;
    chk("i1_drop_ramREN", 32'(ramREN), 32'd0);
    chk("i1_drop_iwait",  32'(iwait), 32'd1);
    edge1; #1;
    chk("i1_idle_ramaddr", ramaddr, 32'd0);
    quiesce;

    // Both request from IDLE; two BUSY cycles then ACCESS.
    edge1;
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300;
    ramstate = RS_BUSY; ramload = 32'h1234_5678;
    #1;
    chk("both_t_ramREN", 32'(ramREN), 32'd0);
    edge1; #1;
    chk("both_t1_ramaddr", ramaddr, 32'h300);
    chk("both_t1_ramREN",  32'(ramREN), 32'd1);
    chk("both_t1_waits",   32'({iwait, dwait}), 32'd3);
    edge1; #1;
    chk("both_t2_waits",   32'({iwait, dwait}), 32'd3);
    edge1;
    ramstate = RS_ACCESS;
    #1;
    chk("both_t3_dwait", 32'(dwait), 32'd0);
    chk("both_t3_iwait", 32'(iwait), 32'd1);
    chk("both_t3_dload", dload, 32'h1234_5678);
    edge1;
    dREN = 1'b0;
    #1;
    chk("both_t4_ramREN", 32'(ramREN), 32'd0);
    chk("both_t4_waits",  32'({iwait, dwait}), 32'd3);
    edge1; #1;
    chk("both_t5_ramaddr", ramaddr, 32'd0);
    edge1; #1;
    chk("both_t6_ramaddr", ramaddr, 32'h80);
    chk("both_t6_ramREN",  32'(ramREN), 32'd1);
    chk("both_t6_iwait",   32'(iwait), 32'd0);
    chk("both_t6_iload",   iload, 32'h1234_5678);
    quiesce;

    // Starvation: dWEN stream with iREN held, RAM always ACCESS.
    edge1;
    iREN = 1'b1; iaddr = 32'hC0; dWEN = 1'b1; daddr = 32'h500; dstore = 32'h0BAD_F00D;
    ramstate = RS_ACCESS;
    #1;
    chk("starve_t_ramWEN", 32'(ramWEN), 32'd0);
    run_seq("starve", "DDDDIDDDD", 9);
    quiesce;

    // ERROR is retried; no icache grant sneaks in.
    edge1;
    dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h44;
    ramstate = RS_ERROR; ramload = 32'hCAFE_0005;
    for (int k = 1; k <= 3; k++) begin
      edge1; #1;
      chk($sformatf("err%0d_waits", k),   32'({iwait, dwait}), 32'd3);
      chk($sformatf("err%0d_ramaddr", k), ramaddr, 32'h100);
      chk($sformatf("err%0d_ramREN", k),  32'(ramREN), 32'd1);
    end
    edge1;
    ramstate = RS_ACCESS;
    #1;
    chk("err_done_dwait", 32'(dwait), 32'd0);
    chk("err_done_iwait", 32'(iwait), 32'd1);
    chk("err_done_dload", dload, 32'hCAFE_0005);
    quiesce;

    // Reset mid-access: build starve_cnt to 3, then reset during BUSY.
    edge1;
    iREN = 1'b1; iaddr = 32'hE0; dWEN = 1'b1; dREN = 1'b1;
    daddr = 32'h200; dstore = 32'h55; ramstate = RS_ACCESS;
    run_seq("pre", "DDD", 3);
    edge1;
    ramstate = RS_BUSY;
    #1;
    chk("busy_ramWEN",  32'(ramWEN), 32'd1);
    chk("busy_ramREN",  32'(ramREN), 32'd0);
    chk("busy_ramaddr", ramaddr, 32'h200);
    chk("busy_ramstore",ramstore, 32'h55);
    chk("busy_dwait",   32'(dwait), 32'd1);
    nRST = 1'b0;
    #1;
    chk("arst_ramWEN",  32'(ramWEN), 32'd0);
    chk("arst_ramaddr", ramaddr, 32'd0);
    chk("arst_ramstore",ramstore, 32'd0);
    chk("arst_waits",   32'({iwait, dwait}), 32'd3);
    edge1;
    nRST = 1'b1;
    ramstate = RS_ACCESS;
    #1;
    chk("post_idle_ramWEN", 32'(ramWEN), 32'd0);
    run_seq("post", "DDDDI", 5);
    quiesce;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
